// File: rtl/ddi_flit_framer.sv
// Die-to-die flit framer: packs payload beats into header-stamped flits
// through an assembly register and an output register.
module ddi_flit_framer #(
  parameter int FLIT_WIDTH    = 256,
  parameter int BEAT_WIDTH    = 32,
  parameter int FLUSH_TIMEOUT = 16,
  parameter int SEQ_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BEAT_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  in_ready,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  err_sop
);

  localparam int PAY_W = FLIT_WIDTH - 32;
  localparam int BPF   = PAY_W / BEAT_WIDTH;
  localparam logic [2:0]  BPF_C   = 3'(BPF);
  localparam logic [15:0] TO_LAST = 16'(FLUSH_TIMEOUT - 1);
  localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = SEQ_WIDTH'(1'b1);

  function automatic logic even_parity(input logic [PAY_W-1:0] d);
    return ^d;
  endfunction

  logic [PAY_W-1:0]      asm_data_r;
  logic [2:0]            asm_cnt_r;
  logic                  asm_sop_r;
  logic                  pend_eop_r;
  logic                  pend_to_r;
  logic                  pend_r;
  logic [15:0]           idle_r;
  logic                  in_ready_r;
  logic [FLIT_WIDTH-1:0] flit_out_r;
  logic                  flit_valid_r;
  logic [SEQ_WIDTH-1:0]  seq_r;
  logic                  err_sop_r;

  logic                  acc_s;
  logic                  to_fire_s;
  logic                  close_s;
  logic                  move_s;
  logic [PAY_W-1:0]      beat_data_s;
  logic [PAY_W-1:0]      c_data_s;
  logic [2:0]            c_cnt_s;
  logic                  c_sop_s;
  logic                  c_eop_s;
  logic                  c_to_s;
  logic [7:0]            seq8_s;
  logic [31:0]           hdr_s;

  assign acc_s     = in_valid && in_ready_r;
  assign to_fire_s = (FLUSH_TIMEOUT != 32'sd0) && !acc_s && !pend_r &&
                     (asm_cnt_r != 3'd0) && (idle_r == TO_LAST);
  assign move_s    = close_s && (!flit_valid_r || flit_ready);

  // Merge the incoming beat into the next free payload slot
  always_comb begin
    beat_data_s = asm_data_r;
    if (asm_cnt_r < BPF_C) begin
      beat_data_s[int'(asm_cnt_r)*BEAT_WIDTH +: BEAT_WIDTH] = in_data;
    end else begin
      beat_data_s = asm_data_r;
    end
  end

  // Select the flit candidate and decide whether it closes this cycle
  always_comb begin
    c_data_s = asm_data_r;
    c_cnt_s  = asm_cnt_r;
    c_sop_s  = asm_sop_r;
    c_eop_s  = pend_eop_r;
    c_to_s   = pend_to_r;
    close_s  = 1'b0;
    if (acc_s) begin
      c_data_s = beat_data_s;
      c_cnt_s  = asm_cnt_r + 3'd1;
      c_sop_s  = (asm_cnt_r == 3'd0) ? in_sop : asm_sop_r;
      c_eop_s  = in_eop;
      c_to_s   = 1'b0;
      close_s  = ((asm_cnt_r + 3'd1) == BPF_C) || in_eop;
    end else if (pend_r) begin
      close_s = 1'b1;
    end else if (to_fire_s) begin
      c_eop_s = 1'b0;
      c_to_s  = 1'b1;
      close_s = 1'b1;
    end else begin
      close_s = 1'b0;
    end
  end

  // Header assembly; seq is zero-extended to the 8-bit field
  always_comb begin
    seq8_s = 8'd0;
    seq8_s[SEQ_WIDTH-1:0] = seq_r;
    hdr_s = {seq8_s, c_cnt_s, c_sop_s, c_eop_s, c_to_s, 17'd0, even_parity(c_data_s)};
  end

  // Output register: loads a closed flit, holds it until the endpoint takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_out_r   <= {FLIT_WIDTH{1'b0}};
      flit_valid_r <= 1'b0;
      seq_r        <= {SEQ_WIDTH{1'b0}};
    end else if (move_s) begin
      flit_out_r   <= {hdr_s, c_data_s};
      flit_valid_r <= 1'b1;
      seq_r        <= seq_r + SEQ_ONE;
    end else if (flit_ready) begin
      flit_valid_r <= 1'b0;
    end
  end

  // Assembly register; doubles as pending storage when the output is blocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_data_r <= {PAY_W{1'b0}};
      asm_cnt_r  <= 3'd0;
      asm_sop_r  <= 1'b0;
      pend_eop_r <= 1'b0;
      pend_to_r  <= 1'b0;
      pend_r     <= 1'b0;
    end else if (close_s && move_s) begin
      asm_data_r <= {PAY_W{1'b0}};
      asm_cnt_r  <= 3'd0;
      asm_sop_r  <= 1'b0;
      pend_eop_r <= 1'b0;
      pend_to_r  <= 1'b0;
      pend_r     <= 1'b0;
    end else if (close_s) begin
      asm_data_r <= c_data_s;
      asm_cnt_r  <= c_cnt_s;
      asm_sop_r  <= c_sop_s;
      pend_eop_r <= c_eop_s;
      pend_to_r  <= c_to_s;
      pend_r     <= 1'b1;
    end else if (acc_s) begin
      asm_data_r <= beat_data_s;
      asm_cnt_r  <= c_cnt_s;
      asm_sop_r  <= c_sop_s;
    end
  end

  // Idle timer, registered ready and sticky SOP-misuse flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_r     <= 16'd0;
      in_ready_r <= 1'b0;
      err_sop_r  <= 1'b0;
    end else begin
      if (acc_s || close_s || pend_r || (asm_cnt_r == 3'd0)) begin
        idle_r <= 16'd0;
      end else begin
        idle_r <= idle_r + 16'd1;
      end
      in_ready_r <= !(close_s && !move_s);
      if (acc_s && in_sop && (asm_cnt_r != 3'd0)) begin
        err_sop_r <= 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign flit_out   = flit_out_r;
  assign flit_valid = flit_valid_r;
  assign err_sop    = err_sop_r;

endmodule
